imem_port_arbiter: RTL

Arbitration controller in front of the single-port instruction block RAM. The RAM has one address, one write enable and a synchronous read with 1-cycle latency. The block shares that one port between two requesters: the program loader (write path) and instruction fetch (read path). The loader has priority, but a starvation counter guarantees fetch forward progress, and read-data valid is tracked per grant.

---
 rtl/imem_port_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Instruction RAM port arbiter: loader writes vs fetch reads.
// Loader wins contention until fetch has waited MAX_WAIT cycles.
module imem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_gnt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        wait_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LD,
    S_IF
  } state_t;

  localparam logic [3:0] MW = 4'(MAX_WAIT);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              both;

  assign both   = ld_req & if_req;
  assign ld_gnt = rst_n & ld_req & (~if_req | (cnt < MW));
  assign if_gnt = rst_n & if_req & (~ld_req | (cnt == MW));

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    unique case (1'b1)
      ld_gnt: begin
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
        mem_wren  = 1'b1;
      end
      if_gnt:  mem_addr = if_addr;
      default: mem_addr = addr_q;
    endcase
  end

  // The FIFO-free read path: a fetch grant last cycle means data now.
  assign if_rvalid = (state == S_IF);
  assign if_rdata  = mem_rdata;
  assign wait_cnt  = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      addr_q <= mem_addr;
      if (ld_gnt)      state <= S_LD;
      else if (if_gnt) state <= S_IF;
      else             state <= S_IDLE;
      if (!if_req || if_gnt) cnt <= '0;
      else if (both)         cnt <= cnt + 4'd1;
    end
  end

endmodule
